// File: rtl/data_memory_pipelined.sv
// Byte-addressable RV32 data memory for the MEM stage.
// One request in flight: accepted in IDLE/RESP/FAULT, then one or two word
// operations (two when the access crosses a word boundary), then a one-cycle
// response pulse. Loads take READ_LATENCY cycles per word, stores one cycle per word.
module data_memory_pipelined #(
    parameter int ADDR_WIDTH     = 13,
    parameter int READ_LATENCY   = 2,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int DEPTH  = 2 ** WORD_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC1,
        S_ACC2,
        S_RESP,
        S_FAULT
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic                split_q, split_d;
    logic [WORD_W-1:0]   word_a_q, word_a_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rd_a_q, rd_a_d;
    logic [31:0]         rd_b_q, rd_b_d;

    logic                accept;
    logic [2:0]          acc_size;
    logic                illegal;
    logic [32:0]         last_addr;
    logic                out_of_range;
    logic                misaligned;
    logic                crosses;
    logic                fault_now;

    logic [WORD_W-1:0]   word_b;
    logic [WORD_W-1:0]   rd_idx;
    logic [31:0]         rd_word;
    logic [3:0]          size_mask;
    logic [63:0]         st_data;
    logic [7:0]          st_mask;
    logic                mem_we;
    logic [WORD_W-1:0]   mem_widx;
    logic [31:0]         mem_wdata;
    logic [3:0]          mem_wmask;
    logic [63:0]         ld_combined;
    logic [31:0]         ld_lo;
    logic [31:0]         ld_data;

    assign req_ready = (state_q == S_IDLE) || (state_q == S_RESP) || (state_q == S_FAULT);
    assign accept    = req_valid && req_ready;
    assign word_b    = word_a_q + WORD_W'(1);

    // Request decode and fault classification, evaluated on the live request at accept
    always_comb begin
        acc_size = 3'd0;
        illegal  = 1'b0;
        case (req_funct3[1:0])
            2'b00:   acc_size = 3'd1;
            2'b01:   acc_size = 3'd2;
            2'b10:   acc_size = 3'd4;
            default: acc_size = 3'd0;
        endcase
        if (req_write) begin
            illegal = (req_funct3 >= 3'b011);
        end else begin
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        end
        last_addr    = {1'b0, req_addr} + 33'(acc_size) - 33'd1;
        out_of_range = (last_addr >> ADDR_WIDTH) != 33'd0;
        misaligned   = ((acc_size == 3'd2) && req_addr[0]) ||
                       ((acc_size == 3'd4) && (req_addr[1:0] != 2'b00));
        crosses      = ({2'b00, req_addr[1:0]} + {1'b0, acc_size}) > 4'd4;
        fault_now    = illegal || out_of_range || (misaligned && (MISALIGN_SPLIT == 0));
    end

    // Store lane placement and memory write port for the word currently being accessed
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        st_data   = {32'h0, wdata_q} << {off_q, 3'b000};
        st_mask   = {4'h0, size_mask} << off_q;
        mem_we    = 1'b0;
        mem_widx  = word_a_q;
        mem_wdata = st_data[31:0];
        mem_wmask = st_mask[3:0];
        if (write_q && (state_q == S_ACC1)) begin
            mem_we = 1'b1;
        end else if (write_q && (state_q == S_ACC2)) begin
            mem_we    = 1'b1;
            mem_widx  = word_b;
            mem_wdata = st_data[63:32];
            mem_wmask = st_mask[7:4];
        end
        rd_idx  = (state_q == S_ACC2) ? word_b : word_a_q;
        rd_word = mem[rd_idx];
    end

    // Little-endian byte combine of the two captured words, then sign/zero extension
    always_comb begin
        ld_combined = {rd_b_q, rd_a_q} >> {off_q, 3'b000};
        ld_lo       = 32'(ld_combined);
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_lo[7]}}, ld_lo[7:0]};
            3'b001:  ld_data = {{16{ld_lo[15]}}, ld_lo[15:0]};
            3'b010:  ld_data = ld_lo;
            3'b100:  ld_data = {24'h0, ld_lo[7:0]};
            3'b101:  ld_data = {16'h0, ld_lo[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

    // Next-state logic: accept/latch, per-word latency counting and read capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        split_d  = split_q;
        word_a_d = word_a_q;
        wdata_d  = wdata_q;
        rd_a_d   = rd_a_q;
        rd_b_d   = rd_b_q;
        case (state_q)
            S_ACC1: begin
                if (write_q) begin
                    state_d = split_q ? S_ACC2 : S_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q == 3'd0) rd_a_d = rd_word;
                    if (cnt_q == 3'(READ_LATENCY - 1)) begin
                        state_d = split_q ? S_ACC2 : S_RESP;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_ACC2: begin
                if (write_q) begin
                    state_d = S_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q == 3'd0) rd_b_d = rd_word;
                    if (cnt_q == 3'(READ_LATENCY - 1)) begin
                        state_d = S_RESP;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    split_d  = crosses;
                    word_a_d = req_addr[ADDR_WIDTH-1:2];
                    wdata_d  = req_wdata;
                    cnt_d    = 3'd0;
                    state_d  = fault_now ? S_FAULT : S_ACC1;
                end
            end
        endcase
    end

    // Control and request registers; reset returns the FSM to IDLE and drops any response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            split_q  <= 1'b0;
            word_a_q <= '0;
            wdata_q  <= 32'h0;
            rd_a_q   <= 32'h0;
            rd_b_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            split_q  <= split_d;
            word_a_q <= word_a_d;
            wdata_q  <= wdata_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
        end
    end

    // Storage array with per-byte write enables; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    assign rsp_valid = (state_q == S_RESP) || (state_q == S_FAULT);
    assign rsp_fault = (state_q == S_FAULT);
    assign rsp_rdata = ((state_q == S_RESP) && !write_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Scoreboard bench: instance 0 uses the defaults (splitting), instance 1 faults on misalignment.
module tb_data_memory_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_fault  [2];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int next_id = 0;

    typedef struct {
        int          d;
        int          id;
        logic [31:0] rdata;
        logic        fault;
        int          due;
    } exp_t;
    exp_t sbq[$];

    data_memory_pipelined #(.ADDR_WIDTH(13), .READ_LATENCY(2), .MISALIGN_SPLIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
    );

    data_memory_pipelined #(.ADDR_WIDTH(13), .READ_LATENCY(2), .MISALIGN_SPLIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (req %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each response, checks latency, data, fault and busy ready
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d]) begin
                    if (sbq.size() == 0 || sbq[0].d != d) begin
                        chk("unexpected_rsp", -1, 32'(d), 32'hFFFF_FFFF);
                    end else begin
                        chk("latency_cycle", sbq[0].id, 32'(cyc), 32'(sbq[0].due));
                        chk("rsp_rdata", sbq[0].id, rsp_rdata[d], sbq[0].rdata);
                        chk("rsp_fault", sbq[0].id, 32'(rsp_fault[d]), 32'(sbq[0].fault));
                        chk("ready_in_rsp", sbq[0].id, 32'(req_ready[d]), 32'd1);
                        void'(sbq.pop_front());
                    end
                end
            end
            if (sbq.size() > 0 && !rsp_valid[sbq[0].d]) begin
                if (cyc >= sbq[0].due) begin
                    chk("rsp_timeout", sbq[0].id, 32'(cyc), 32'(sbq[0].due));
                    void'(sbq.pop_front());
                end else begin
                    chk("ready_busy", sbq[0].id, 32'(req_ready[sbq[0].d]), 32'd0);
                end
            end
        end
    end

    // Present a request, hold it until accepted, then push the expected response
    task automatic issue(input int d, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input bit ef,
                         input int n, input bit expect_rsp);
        int k;
        exp_t e;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        k = 0;
        while (!req_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            chk("accept_timeout", next_id, 32'(k), 32'd0);
            req_valid[d] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (expect_rsp) begin
                e.d = d; e.id = next_id; e.rdata = er; e.fault = ef; e.due = cyc + n - 1;
                sbq.push_back(e);
            end
        end
        next_id++;
    endtask

    task automatic drain(input int d);
        int k;
        @(negedge clk);
        req_valid[d] = 1'b0;
        k = 0;
        while (sbq.size() > 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            chk("drain_timeout", next_id, 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", d, 32'(req_ready[d]), 32'd1);
            chk("reset_valid", d, 32'(rsp_valid[d]), 32'd0);
            chk("reset_rdata", d, rsp_rdata[d], 32'h0);
            chk("reset_fault", d, 32'(rsp_fault[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Instance 0: aligned traffic, chained back-to-back
        issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 1);
        issue(0, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 3, 1);
        issue(0, 0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFDE, 0, 3, 1);
        issue(0, 0, 3'b100, 32'h103, 32'h0,        32'h000000DE, 0, 3, 1);
        issue(0, 1, 3'b001, 32'h202, 32'h00008001, 32'h0,        0, 2, 1);
        issue(0, 0, 3'b001, 32'h202, 32'h0,        32'hFFFF8001, 0, 3, 1);
        issue(0, 0, 3'b101, 32'h202, 32'h0,        32'h00008001, 0, 3, 1);
        issue(0, 0, 3'b010, 32'h200, 32'h0,        32'h80010000, 0, 3, 1);
        // Split accesses
        issue(0, 1, 3'b010, 32'h105, 32'h11223344, 32'h0,        0, 3, 1);
        issue(0, 0, 3'b010, 32'h105, 32'h0,        32'h11223344, 0, 5, 1);
        issue(0, 0, 3'b010, 32'h104, 32'h0,        32'h22334400, 0, 3, 1);
        issue(0, 0, 3'b010, 32'h108, 32'h0,        32'h00000011, 0, 3, 1);
        issue(0, 0, 3'b001, 32'h107, 32'h0,        32'h00001122, 0, 5, 1);
        issue(0, 0, 3'b001, 32'h105, 32'h0,        32'h00003344, 0, 3, 1);
        issue(0, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 3, 1);
        // Faults and range edges
        issue(0, 0, 3'b011, 32'h000, 32'h0,        32'h0,        1, 1, 1);
        issue(0, 1, 3'b011, 32'h000, 32'h12345678, 32'h0,        1, 1, 1);
        issue(0, 0, 3'b010, 32'h1FFE, 32'h0,       32'h0,        1, 1, 1);
        issue(0, 0, 3'b010, 32'h1FFC, 32'h0,       32'h0,        0, 3, 1);
        issue(0, 0, 3'b000, 32'h2000, 32'h0,       32'h0,        1, 1, 1);
        issue(0, 0, 3'b000, 32'h80000000, 32'h0,   32'h0,        1, 1, 1);
        issue(0, 0, 3'b010, 32'h000, 32'h0,        32'h12345678 & 32'h0, 0, 3, 1);
        drain(0);

        // Instance 1: misaligned requests fault and leave memory untouched
        issue(1, 1, 3'b010, 32'h104, 32'hAABBCCDD, 32'h0,        0, 2, 1);
        issue(1, 0, 3'b010, 32'h105, 32'h0,        32'h0,        1, 1, 1);
        issue(1, 1, 3'b010, 32'h105, 32'h01020304, 32'h0,        1, 1, 1);
        issue(1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 1, 1);
        issue(1, 1, 3'b101, 32'h104, 32'h01020304, 32'h0,        1, 1, 1);
        issue(1, 0, 3'b010, 32'h104, 32'h0,        32'hAABBCCDD, 0, 3, 1);
        issue(1, 0, 3'b010, 32'h108, 32'h0,        32'h00000000, 0, 3, 1);
        issue(1, 0, 3'b011, 32'h104, 32'h0,        32'h0,        1, 1, 1);
        issue(1, 0, 3'b010, 32'h1FFE, 32'h0,       32'h0,        1, 1, 1);
        issue(1, 0, 3'b010, 32'h1FFC, 32'h0,       32'h0,        0, 3, 1);
        issue(1, 0, 3'b001, 32'h106, 32'h0,        32'hFFFFAABB, 0, 3, 1);
        drain(1);

        // Reset in the second word of a split store
        issue(0, 1, 3'b010, 32'h300, 32'h55555555, 32'h0,        0, 2, 1);
        issue(0, 1, 3'b010, 32'h304, 32'h55555555, 32'h0,        0, 2, 1);
        drain(0);
        issue(0, 1, 3'b010, 32'h302, 32'hA1B2C3D4, 32'h0,        0, 3, 0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", next_id, 32'(rsp_valid[0]), 32'd0);
        chk("midrst_ready", next_id, 32'(req_ready[0]), 32'd1);
        chk("midrst_rdata", next_id, rsp_rdata[0], 32'h0);
        chk("midrst_fault", next_id, 32'(rsp_fault[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 0, 3'b010, 32'h300, 32'h0,        32'hC3D45555, 0, 3, 1);
        issue(0, 0, 3'b010, 32'h304, 32'h0,        32'h55555555, 0, 3, 1);
        drain(0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
